add_sub_accumulator: RTL and testbench

ADD_SUB_ACCUMULATOR -- requirements
Module: add_sub_accumulator

---
 rtl/add_sub_accumulator.sv | 121 ++++++++++++
 tb/tb_add_sub_accumulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_accumulator.sv
// Accumulator sequencing LOAD/ADD/SUB/CLRF commands through an external
// adder/subtractor stage, reporting the result and flags over a valid/ready handshake.
module add_sub_accumulator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [7:0] operand,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_s,
  input  logic [7:0] add_c,
  input  logic       add_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] acc,
  output logic [4:0] flags
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLRF = 2'b11} op_t;

  state_t     state, state_nxt;
  op_t        op_q;
  logic       sticky_q, ovf_q, carry_q, neg_q, zero_q;
  logic [7:0] acc_nxt;
  logic       sticky_nxt, ovf_nxt, carry_nxt;
  logic       unused_carry;

  // Overflow arrives precomputed on add_ovf; the lower carry bits are not needed.
  assign unused_carry = ^add_c[6:0];

  assign flags = {sticky_q, ovf_q, carry_q, neg_q, zero_q};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: state_nxt = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt    = acc;
    ovf_nxt    = ovf_q;
    carry_nxt  = carry_q;
    sticky_nxt = sticky_q;
    case (op_q)
      OP_ADD, OP_SUB: begin
        acc_nxt    = add_s;
        ovf_nxt    = add_ovf;
        carry_nxt  = add_c[7];
        sticky_nxt = sticky_q | add_ovf;
      end
      OP_LOAD: begin
        acc_nxt   = add_b;
        ovf_nxt   = 1'b0;
        carry_nxt = 1'b0;
      end
      OP_CLRF: begin
        ovf_nxt    = 1'b0;
        carry_nxt  = 1'b0;
        sticky_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_LOAD;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      acc      <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op_t'(op);
            add_a   <= acc;
            add_b   <= operand;
            add_cin <= (op_t'(op) == OP_SUB);
          end
        end
        CALC: begin
          acc      <= acc_nxt;
          ovf_q    <= ovf_nxt;
          carry_q  <= carry_nxt;
          sticky_q <= sticky_nxt;
          zero_q   <= (acc_nxt == 8'h00);
          neg_q    <= acc_nxt[7];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Bench for add_sub_accumulator: directed command table, reset-in-flight
// sequence and randomized traffic checked against an arithmetic reference model.
module tb_add_sub_accumulator;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, add_cin, add_ovf, out_valid, out_ready;
  logic [1:0] op;
  logic [7:0] operand, add_a, add_b, add_s, add_c, acc;
  logic [4:0] flags;

  always #5 clk = ~clk;

  add_sub_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand(operand), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_c(add_c), .add_ovf(add_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .acc(acc), .flags(flags)
  );

  // Downstream ripple adder/subtractor stage the block drives.
  logic env_cy, env_bb;
  always_comb begin
    env_cy = add_cin;
    env_bb = 1'b0;
    add_s  = '0;
    add_c  = '0;
    for (int i = 0; i < 8; i++) begin
      env_bb   = add_b[i] ^ add_cin;
      add_s[i] = add_a[i] ^ env_bb ^ env_cy;
      env_cy   = (add_a[i] & env_bb) | (env_cy & (add_a[i] ^ env_bb));
      add_c[i] = env_cy;
    end
  end
  assign add_ovf = add_c[7] ^ add_c[6];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural values.
  logic [7:0] m_acc;
  logic [4:0] m_flags;

  task automatic model(input logic [1:0] o, input logic [7:0] d);
    int sa, sd, sv, u;
    logic sticky, ov, cy;
    logic [7:0] r;
    sticky = m_flags[4];
    sa = $signed(m_acc);
    sd = $signed(d);
    r  = m_acc;
    ov = 1'b0;
    cy = 1'b0;
    case (o)
      2'b00: r = d;
      2'b01: begin
        u  = int'(m_acc) + int'(d);
        r  = u[7:0];
        cy = (u > 255);
        sv = sa + sd;
        ov = (sv > 127) || (sv < -128);
      end
      2'b10: begin
        u  = int'(m_acc) - int'(d);
        r  = u[7:0];
        cy = (m_acc >= d);
        sv = sa - sd;
        ov = (sv > 127) || (sv < -128);
      end
      default: sticky = 1'b0;
    endcase
    sticky  = sticky | ov;
    m_acc   = r;
    m_flags = {sticky, ov, cy, r[7], (r == 8'h00)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full command: accept, CALC, RESP with `stall` backpressure cycles, release.
  task automatic cmd(input logic [1:0] o, input logic [7:0] d, input int stall);
    int n;
    logic [7:0] prev_acc, hold_acc;
    logic [4:0] hold_flags;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("idle_wait", in_ready, 1'b1);
    prev_acc = m_acc;
    in_valid = 1'b1; op = o; operand = d;
    tick();
    in_valid = 1'b0; op = 2'($urandom); operand = 8'($urandom);
    chk("accept_add_a", add_a, prev_acc);
    chk("accept_add_b", add_b, d);
    chk("accept_add_cin", add_cin, (o == 2'b10));
    chk("calc_out_valid", out_valid, 1'b0);
    chk("calc_in_ready", in_ready, 1'b0);
    model(o, d);
    tick();
    chk("resp_out_valid", out_valid, 1'b1);
    chk("resp_acc", acc, m_acc);
    chk("resp_flags", flags, m_flags);
    hold_acc = acc;
    hold_flags = flags;
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      in_valid = 1'($urandom); op = 2'($urandom); operand = 8'($urandom);
      tick();
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_acc", acc, hold_acc);
      chk("stall_flags", flags, hold_flags);
      chk("stall_add_b", add_b, d);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_in_ready", in_ready, 1'b1);
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_acc", acc, m_acc);
  endtask

  typedef struct {
    logic [1:0] o;
    logic [7:0] d;
    int         stall;
    logic [7:0] exp_acc;
    logic [4:0] exp_flags;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int since;
    logic was_ready, was_ov, d_iv, d_or;
    logic [1:0] d_op;
    logic [7:0] d_opnd;

    vecs[0]  = '{2'b00, 8'hFF, 0, 8'hFF, 5'b00010};
    vecs[1]  = '{2'b01, 8'h01, 1, 8'h00, 5'b00101};
    vecs[2]  = '{2'b00, 8'h7F, 0, 8'h7F, 5'b00000};
    vecs[3]  = '{2'b01, 8'h01, 5, 8'h80, 5'b11010};
    vecs[4]  = '{2'b00, 8'h01, 2, 8'h01, 5'b10000};
    vecs[5]  = '{2'b11, 8'h00, 0, 8'h01, 5'b00000};
    vecs[6]  = '{2'b00, 8'h80, 0, 8'h80, 5'b00010};
    vecs[7]  = '{2'b10, 8'h01, 3, 8'h7F, 5'b11100};
    vecs[8]  = '{2'b00, 8'h6C, 0, 8'h6C, 5'b10000};
    vecs[9]  = '{2'b10, 8'hCA, 1, 8'hA2, 5'b11010};
    vecs[10] = '{2'b11, 8'h33, 0, 8'hA2, 5'b00010};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; operand = '0; out_ready = 1'b0;
    tick(); tick();
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_acc", acc, 8'h00);
    chk("reset_flags", flags, 5'b00001);
    chk("reset_add_ab", {add_a, add_b, add_cin}, 17'h0);
    rst_n = 1'b1;
    m_acc = 8'h00;
    m_flags = 5'b00001;
    tick();

    foreach (vecs[i]) begin
      cmd(vecs[i].o, vecs[i].d, vecs[i].stall);
      chk($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
      chk($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
    end

    // Reset while the ADD is in CALC drops it without a response.
    cmd(2'b00, 8'hAA, 0);
    in_valid = 1'b1; op = 2'b01; operand = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("inflight_calc", {in_ready, out_valid}, 2'b00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_acc = 8'h00;
    m_flags = 5'b00001;
    chk("rst_calc_out_valid", out_valid, 1'b0);
    chk("rst_calc_acc", acc, 8'h00);
    chk("rst_calc_flags", flags, 5'b00001);
    chk("rst_calc_add_a", add_a, 8'h00);
    tick();
    chk("after_rst_in_ready", in_ready, 1'b1);
    chk("after_rst_out_valid", out_valid, 1'b0);

    // Randomized traffic; first phase holds in_valid high for back-to-back commands.
    since = 100;
    for (int c = 0; c < 600; c++) begin
      d_iv   = (c < 200) ? 1'b1 : 1'($urandom_range(0, 1));
      d_or   = ($urandom_range(0, 3) != 0);
      d_op   = 2'($urandom);
      d_opnd = 8'($urandom);
      in_valid = d_iv; op = d_op; operand = d_opnd; out_ready = d_or;
      was_ready = in_ready;
      was_ov = out_valid;
      tick();
      since++;
      if (was_ready && d_iv) begin
        chk("rnd_add_a", add_a, m_acc);
        chk("rnd_add_b", add_b, d_opnd);
        chk("rnd_add_cin", add_cin, (d_op == 2'b10));
        chk("rnd_one_accept", in_ready, 1'b0);
        model(d_op, d_opnd);
        since = 0;
      end else if (since == 1) begin
        chk("rnd_latency", out_valid, 1'b1);
        chk("rnd_acc", acc, m_acc);
        chk("rnd_flags", flags, m_flags);
      end
      if (was_ov && d_or) chk("rnd_release", {in_ready, out_valid}, 2'b10);
      if (was_ov && !d_or) chk("rnd_hold", {out_valid, acc, flags}, {1'b1, m_acc, m_flags});
      if (in_ready && out_valid) chk("rnd_exclusive", 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
